// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//
// Handshake: the master raises start with a_in/b_in/cin_in valid; the
// slave captures them on any rising edge where start=1 and it is idle or
// done (busy=0). start seen while busy=1 is ignored, so the master treats
// busy=0 as "ready". Exactly WIDTH clocks after the capture edge, done
// pulses for one cycle; sum_out/cout_out are valid from that cycle on and
// stay put until the next operation completes.
//
// Signals:
//   start     master->slave  operation request
//   a_in      master->slave  operand A
//   b_in      master->slave  operand B
//   cin_in    master->slave  carry-in
//   busy      slave->master  high while bits are being shifted
//   done      slave->master  one-cycle completion pulse
//   sum_out   slave->master  A+B+cin mod 2^WIDTH
//   cout_out  slave->master  carry-out of the MSB
//   state_dbg slave->master  FSM state (0=IDLE, 1=SHIFT, 2=DONE)
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic [1:0]       state_dbg;

  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out, state_dbg
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out, state_dbg
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using a single 1-bit full adder.
// Operands are captured on an accepted start, then one bit pair per clock
// (LSB first) goes through the full adder. The carry register closes the
// cout->cin loop and sum bits are shifted into a result register.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  serial_adder_if slave (start/operands in, busy/done/result out)

// 1-bit full adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ c_i;
  assign cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] s_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_sr_d;

  full_adder f (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .c_i   (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    s_sr_d = (s_sr_q >> 1) | ({{(WIDTH-1){1'b0}}, fa_sum} << (WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        // DONE accepts exactly like IDLE so back-to-back ops have no bubble.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr_q  <= bus.a_in;
            b_sr_q  <= bus.b_in;
            carry_q <= bus.cin_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          s_sr_q  <= s_sr_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= s_sr_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum_out   = sum_q;
  assign bus.cout_out  = cout_q;
  assign bus.state_dbg = state_q;
endmodule
